// File: rtl/mc_hst_q.sv
// mc_hst_q: in-order host request queue (queued -> granted -> complete).
// Optional sticky error checks built with MC_HST_Q_ERRCHK_EN.
module mc_hst_q #(
  parameter int ADDR_W = 23,
  parameter int DEPTH  = 4,
  parameter int PAGE_W = 2
) (
  input  logic                     mclock,
  input  logic                     reset,
  input  logic                     hst_req,
  input  logic [ADDR_W-1:0]        hst_org,
  input  logic                     hst_read,
  input  logic [PAGE_W-1:0]        hst_page,
  output logic                     hst_rdy,
  output logic                     hst_arb_req,
  output logic [ADDR_W-1:0]        hst_arb_addr,
  output logic                     hst_arb_read,
  output logic [PAGE_W-1:0]        hst_arb_page,
  input  logic                     hst_gnt,
  input  logic                     rc_push_en,
  input  logic                     rc_pop_en,
  output logic                     hst_push,
  output logic                     hst_pop,
  output logic [PAGE_W-1:0]        hst_mw_addr,
  output logic                     hst_done,
  output logic [$clog2(DEPTH):0]   hst_level,
  output logic [2:0]               hst_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic              read_q [DEPTH];
  logic [PAGE_W-1:0] page_q [DEPTH];

  logic [PW-1:0]     wr_ptr, gnt_ptr, cmp_ptr;
  logic [LW-1:0]     level, q_cnt;
  logic [PAGE_W-1:0] beat_cnt;
  logic              done_q, push_q, pop_q;

  logic inflight, cur_read, accept, grant;
  logic beat_ok, complete;
  logic [PAGE_W-1:0] cur_page;

  // q_cnt holds ungranted entries; the rest of level is granted
  assign inflight = (level != q_cnt);
  assign cur_read = read_q[cmp_ptr];
  assign cur_page = page_q[cmp_ptr];
  assign hst_rdy  = !reset && (level < LW'(DEPTH));
  assign accept   = hst_req && hst_rdy;
  assign hst_arb_req = (q_cnt != '0);
  assign grant    = hst_gnt && hst_arb_req;
  assign beat_ok  = inflight && (cur_read ? rc_push_en : rc_pop_en);
  assign complete = beat_ok && (beat_cnt == cur_page);

  assign hst_arb_addr = hst_arb_req ? addr_q[gnt_ptr] : '0;
  assign hst_arb_read = hst_arb_req ? read_q[gnt_ptr] : 1'b0;
  assign hst_arb_page = hst_arb_req ? page_q[gnt_ptr] : '0;
  assign hst_mw_addr  = (inflight && !cur_read) ? beat_cnt : '0;
  assign hst_level    = level;
  assign hst_done     = done_q;
  assign hst_push     = push_q;
  assign hst_pop      = pop_q;

  // entry storage, written at the tail on accept
  always_ff @(posedge mclock) begin
    if (accept) begin
      addr_q[wr_ptr] <= hst_org;
      read_q[wr_ptr] <= hst_read;
      page_q[wr_ptr] <= hst_page;
    end
  end

  // pointers, occupancy, beat counter and strobes
  always_ff @(posedge mclock) begin
    if (reset) begin
      wr_ptr   <= '0;
      gnt_ptr  <= '0;
      cmp_ptr  <= '0;
      level    <= '0;
      q_cnt    <= '0;
      beat_cnt <= '0;
      done_q   <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
    end else begin
      push_q <= rc_push_en;
      pop_q  <= rc_pop_en;
      done_q <= complete;
      if (accept)
        wr_ptr <= wr_ptr + PW'(1);
      if (grant)
        gnt_ptr <= gnt_ptr + PW'(1);
      if (complete) begin
        cmp_ptr  <= cmp_ptr + PW'(1);
        beat_cnt <= '0;
      end else if (beat_ok) begin
        beat_cnt <= beat_cnt + PAGE_W'(1);
      end
      level <= level + LW'(accept) - LW'(complete);
      q_cnt <= q_cnt + LW'(accept) - LW'(grant);
    end
  end

`ifdef MC_HST_Q_ERRCHK_EN
  logic [2:0] err_q;
  logic       bad_beat;

  assign bad_beat = inflight
                  ? (cur_read ? rc_pop_en : rc_push_en)
                  : (rc_push_en || rc_pop_en);

  // sticky protocol error flags
  always_ff @(posedge mclock) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      if (hst_gnt && !hst_arb_req) err_q[0] <= 1'b1;
      if (bad_beat)                err_q[1] <= 1'b1;
      if (hst_req && !hst_rdy)     err_q[2] <= 1'b1;
    end
  end

  assign hst_err = err_q;
`else
  assign hst_err = 3'b000;
`endif

endmodule

// File: tb/tb_mc_hst_q.sv
// tb_mc_hst_q: directed + random stimulus against a queue-based model.
// Expects hst_err checks only when MC_HST_Q_ERRCHK_EN is defined.
module tb_mc_hst_q;

  localparam int AW  = 23;
  localparam int D   = 4;
  localparam int PGW = 2;

  logic           mclock = 1'b0;
  logic           reset;
  logic           hst_req;
  logic [AW-1:0]  hst_org;
  logic           hst_read;
  logic [PGW-1:0] hst_page;
  logic           hst_rdy;
  logic           hst_arb_req;
  logic [AW-1:0]  hst_arb_addr;
  logic           hst_arb_read;
  logic [PGW-1:0] hst_arb_page;
  logic           hst_gnt;
  logic           rc_push_en;
  logic           rc_pop_en;
  logic           hst_push;
  logic           hst_pop;
  logic [PGW-1:0] hst_mw_addr;
  logic           hst_done;
  logic [2:0]     hst_level;
  logic [2:0]     hst_err;

  always #5 mclock = ~mclock;

  mc_hst_q #(.ADDR_W(AW), .DEPTH(D), .PAGE_W(PGW)) dut (
    .mclock       (mclock),
    .reset        (reset),
    .hst_req      (hst_req),
    .hst_org      (hst_org),
    .hst_read     (hst_read),
    .hst_page     (hst_page),
    .hst_rdy      (hst_rdy),
    .hst_arb_req  (hst_arb_req),
    .hst_arb_addr (hst_arb_addr),
    .hst_arb_read (hst_arb_read),
    .hst_arb_page (hst_arb_page),
    .hst_gnt      (hst_gnt),
    .rc_push_en   (rc_push_en),
    .rc_pop_en    (rc_pop_en),
    .hst_push     (hst_push),
    .hst_pop      (hst_pop),
    .hst_mw_addr  (hst_mw_addr),
    .hst_done     (hst_done),
    .hst_level    (hst_level),
    .hst_err      (hst_err)
  );

  typedef struct {
    logic [AW-1:0]  a;
    logic           rd;
    logic [PGW-1:0] pg;
  } ent_t;

  ent_t       pend[$];
  ent_t       fly[$];
  int         beats;
  logic       m_done, m_push, m_pop;
  logic [2:0] m_err;
  int         n_vec, n_bad, n_done_seen;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic rq, input logic [AW-1:0] o,
                     input logic rd, input logic [PGW-1:0] pg,
                     input logic g, input logic pu, input logic po,
                     input logic rs);
    hst_req    = rq;
    hst_org    = o;
    hst_read   = rd;
    hst_page   = pg;
    hst_gnt    = g;
    rc_push_en = pu;
    rc_pop_en  = po;
    reset      = rs;
  endtask

  task automatic idle();
    set(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // check outputs, then advance one edge and update the model
  task automatic tick();
    int   sz;
    logic arb, inf, acc, gr, ok, cp, bad;
    ent_t e;
    #1;
    sz  = pend.size() + fly.size();
    arb = pend.size() > 0;
    inf = fly.size() > 0;
    chk("rdy", hst_rdy, (!reset && sz < D));
    chk("level", hst_level, sz);
    chk("arb_req", hst_arb_req, arb);
    if (arb) begin
      chk("arb_addr", hst_arb_addr, pend[0].a);
      chk("arb_read", hst_arb_read, pend[0].rd);
      chk("arb_page", hst_arb_page, pend[0].pg);
    end else begin
      chk("arb_addr", hst_arb_addr, 0);
      chk("arb_read", hst_arb_read, 0);
      chk("arb_page", hst_arb_page, 0);
    end
    if (inf && !fly[0].rd) chk("mw_addr", hst_mw_addr, beats);
    else                   chk("mw_addr", hst_mw_addr, 0);
    chk("done", hst_done, m_done);
    chk("push", hst_push, m_push);
    chk("pop", hst_pop, m_pop);
`ifdef MC_HST_Q_ERRCHK_EN
    chk("err", hst_err, m_err);
`else
    chk("err", hst_err, 0);
`endif
    if (hst_done === 1'b1) n_done_seen++;
    @(posedge mclock);
    if (reset) begin
      pend.delete();
      fly.delete();
      beats  = 0;
      m_done = 0;
      m_push = 0;
      m_pop  = 0;
      m_err  = 0;
    end else begin
      acc = hst_req && (sz < D);
      gr  = hst_gnt && arb;
      ok  = inf && (fly[0].rd ? rc_push_en : rc_pop_en);
      cp  = ok && (beats == int'(fly[0].pg));
      bad = inf ? (fly[0].rd ? rc_pop_en : rc_push_en)
                : (rc_push_en || rc_pop_en);
      if (hst_gnt && !arb) m_err[0] = 1'b1;
      if (bad)             m_err[1] = 1'b1;
      if (hst_req && !(sz < D)) m_err[2] = 1'b1;
      m_done = cp;
      m_push = rc_push_en;
      m_pop  = rc_pop_en;
      if (cp) begin
        void'(fly.pop_front());
        beats = 0;
      end else if (ok) begin
        beats++;
      end
      if (gr) fly.push_back(pend.pop_front());
      if (acc) begin
        e.a = hst_org; e.rd = hst_read; e.pg = hst_page;
        pend.push_back(e);
      end
    end
    @(negedge mclock);
  endtask

  initial begin
    n_vec = 0; n_bad = 0; n_done_seen = 0; beats = 0;
    m_done = 0; m_push = 0; m_pop = 0; m_err = 0;
    idle();
    reset = 1'b1;
    @(negedge mclock);
    tick();
    tick();
    idle();
    tick();
    chk("post_reset_rdy", hst_rdy, 1);

    // read: org 0x12345, page 3, grant, 4 push beats
    n_done_seen = 0;
    set(1'b1, 23'h12345, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rd_level1", hst_level, 1);
    set(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    idle();
    tick();
    tick();
    chk("rd_done_once", n_done_seen, 1);
    chk("rd_level0", hst_level, 0);

    // fill with A..D (reads, page 0), then a 5th request
    for (int i = 0; i < 4; i++) begin
      set(1'b1, AW'(32'hA0 + i), 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("fill_level", hst_level, 4);
    chk("fill_rdy", hst_rdy, 0);
    set(1'b1, 23'h7FFFFF, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fill_level5", hst_level, 4);

    // grant A, complete A, then accept E on the following edge
    set(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("full_cmp_level", hst_level, 3);
    set(1'b1, 23'hE4, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("full_acc_level", hst_level, 4);
    chk("order_head_B", hst_arb_addr, 32'hA1);
    for (int i = 0; i < 10; i++) begin
      set(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    idle();
    tick();

    // write page 1: two pop beats
    set(1'b1, 23'h00F00, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wr_mw0", hst_mw_addr, 0);
    set(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("wr_mw1", hst_mw_addr, 1);
    tick();
    chk("wr_mw_end", hst_mw_addr, 0);
    idle();
    tick();

    // reset in the middle of a burst, then a normal request
    set(1'b1, 23'h00BEE, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    n_done_seen = 0;
    set(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    chk("rst_mid_level", hst_level, 0);
    chk("rst_mid_arb", hst_arb_req, 0);
    tick();
    chk("rst_mid_nodone", n_done_seen, 0);
    set(1'b1, 23'h00123, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("rst_then_done", n_done_seen, 1);

    // spurious grant on an empty queue
    set(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("spur_level", hst_level, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      set(1'($urandom_range(0, 1)), AW'($urandom()),
          1'($urandom_range(0, 1)), PGW'($urandom_range(0, 3)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
